// File: rtl/goldsmith_div_pipe_if.sv
// goldsmith_div_pipe_if: operand/result handshake bundle for the Goldschmidt divider
interface goldsmith_div_pipe_if #(parameter int W = 32);
  logic in_valid;
  logic in_ready;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic abort;
  logic out_valid;
  logic out_ready;
  logic [W-1:0] quotient;
  logic div_zero;
  logic ovf;
  modport master (output in_valid, dividend, divisor, abort, out_ready,
                  input in_ready, out_valid, quotient, div_zero, ovf);
  modport slave (input in_valid, dividend, divisor, abort, out_ready,
                 output in_ready, out_valid, quotient, div_zero, ovf);
endinterface

// File: rtl/goldsmith_div_pipe.sv
// goldsmith_div_pipe: iterative Goldschmidt fixed-point divider; GSDIV_SIGNED_EN selects two's complement operands
module goldsmith_div_pipe #(
  parameter int W = 32,
  parameter int F = 23,
  parameter int ITERS = 5,
  parameter int GUARD = 4
) (
  input logic clk,
  input logic reset,
  goldsmith_div_pipe_if.slave bus
);
  localparam int FG = F + GUARD;
  localparam int NW = W + GUARD + 2;
  localparam int DW = FG + 2;
  localparam int XW = NW + F;
  localparam int MW = $clog2(W + 1);
  localparam int CW = $clog2(ITERS + 1);
  localparam logic [DW-1:0] two = DW'(2) << FG;
  typedef enum logic [1:0] {IDLE, NORM, ITER, DONE} state_t;
  state_t st, nx;
  logic [W:0] a, b, am, bm, nrm;
  logic signed [7:0] s, sc, sh;
  logic [MW-1:0] m;
  logic [DW-1:0] d, f, d0, f0, dn;
  logic [NW-1:0] n, nn;
  logic [NW+DW-1:0] nf;
  logic [2*DW-1:0] df;
  logic [XW-1:0] qx;
  logic [CW-1:0] cnt;
  logic [W-1:0] quotient, qs, qz, sat;
  logic div_zero, ovf, qo;
`ifdef GSDIV_SIGNED_EN
  logic sa, neg;
  assign am = bus.dividend[W-1] ? -{bus.dividend[W-1], bus.dividend} : {1'b0, bus.dividend};
  assign bm = bus.divisor[W-1] ? -{bus.divisor[W-1], bus.divisor} : {1'b0, bus.divisor};
  assign sat = neg ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
  assign qz = sa ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
  // a negative result may reach exactly 2^(W-1); anything larger saturates
  assign qo = |qx[XW-1:W] | (qx[W-1] & (~neg | |qx[W-2:0]));
  assign qs = neg ? -qx[W-1:0] : qx[W-1:0];
  always_ff @(posedge clk)
    if (reset) begin
      sa <= 1'b0;
      neg <= 1'b0;
    end else if (st == IDLE && bus.in_valid) begin
      sa <= bus.dividend[W-1];
      neg <= bus.dividend[W-1] ^ bus.divisor[W-1];
    end
`else
  assign am = {1'b0, bus.dividend};
  assign bm = {1'b0, bus.divisor};
  assign sat = '1;
  assign qz = '1;
  assign qo = |qx[XW-1:W];
  assign qs = qx[W-1:0];
`endif
  always_comb begin
    m = '0;
    for (int i = 0; i <= W; i++) if (b[i]) m = MW'(i);
    sc = 8'(F - 1) - 8'(m);
    nrm = b << (MW'(W - 1) - m);
    d0 = DW'({nrm, {FG{1'b0}}} >> W);
    f0 = two - d0;
    nf = {{DW{1'b0}}, n} * {{NW{1'b0}}, f};
    df = {{DW{1'b0}}, d} * {{DW{1'b0}}, f};
    nn = NW'(nf >> FG);
    dn = DW'(df >> FG);
    sh = s - 8'(GUARD);
    qx = sh[7] ? (XW'(n) >> $unsigned(-sh)) : (XW'(n) << $unsigned(sh));
  end
  always_comb begin
    nx = st;
    case (st)
      IDLE: nx = bus.in_valid ? NORM : IDLE;
      NORM: nx = ~|b ? DONE : ITER;
      ITER: nx = (cnt == CW'(ITERS)) ? DONE : ITER;
      DONE: nx = bus.out_ready ? IDLE : DONE;
      default: nx = IDLE;
    endcase
    if (bus.abort && st != IDLE) nx = IDLE;
  end
  always_ff @(posedge clk) st <= reset ? IDLE : nx;
  // ITER spends ITERS cycles iterating and one more denormalising into the result
  always_ff @(posedge clk)
    if (reset) begin
      {a, b, n, d, f, s, cnt} <= '0;
      {quotient, div_zero, ovf} <= '0;
    end else
      case (st)
        IDLE: if (bus.in_valid) begin
          a <= am;
          b <= bm;
        end
        NORM: begin
          n <= NW'(a) << GUARD;
          d <= d0;
          f <= f0;
          s <= sc;
          cnt <= '0;
          if (~|b) begin
            quotient <= qz;
            div_zero <= 1'b1;
            ovf <= 1'b0;
          end
        end
        ITER: if (cnt != CW'(ITERS)) begin
          n <= nn;
          d <= dn;
          f <= two - dn;
          cnt <= cnt + 1'b1;
        end else begin
          quotient <= qo ? sat : qs;
          ovf <= qo;
          div_zero <= 1'b0;
        end
        default: ;
      endcase
  assign bus.in_ready = st == IDLE;
  assign bus.out_valid = st == DONE;
  assign bus.quotient = quotient;
  assign bus.div_zero = div_zero;
  assign bus.ovf = ovf;
endmodule

// File: tb/tb_goldsmith_div_pipe.sv
// tb_goldsmith_div_pipe: directed-vector bench for goldsmith_div_pipe
module tb_goldsmith_div_pipe;
  localparam int W = 32;
  localparam int ITERS = 5;
`ifdef GSDIV_SIGNED_EN
  localparam logic [W-1:0] SAT_POS = 32'h7FFF_FFFF;
`else
  localparam logic [W-1:0] SAT_POS = 32'hFFFF_FFFF;
`endif
  logic clk = 1'b0;
  logic reset = 1'b1;
  int nv = 0;
  int nf = 0;
  always #5 clk = ~clk;
  goldsmith_div_pipe_if #(.W(W)) bus ();
  goldsmith_div_pipe #(.W(W), .F(23), .ITERS(ITERS), .GUARD(4)) dut (.clk(clk), .reset(reset), .bus(bus));
  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    nv++;
    assert (obs === exp) else begin
      nf++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic chk_tol(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    logic [W-1:0] near;
    near = (obs === exp + 1 || obs === exp - 1) ? exp : obs;
    chk(tag, near, exp);
  endtask
  task automatic start(input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.dividend = x;
    bus.divisor = y;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask
  task automatic wait_valid(output int lat);
    lat = 0;
    while (lat < 30) begin
      @(negedge clk);
      if (bus.out_valid) break;
      lat++;
    end
  endtask
  task automatic take(input string tag);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk({tag, ".in_ready"}, W'(bus.in_ready), 1);
    chk({tag, ".out_valid_drop"}, W'(bus.out_valid), 0);
  endtask
  task automatic run(input string tag, input logic [W-1:0] x, input logic [W-1:0] y, input logic [W-1:0] exp,
                     input bit edz, input bit eov, input int elat, input bit tol);
    int lat;
    start(x, y);
    wait_valid(lat);
    chk({tag, ".latency"}, W'(lat), W'(elat));
    if (tol) chk_tol({tag, ".quotient"}, bus.quotient, exp);
    else chk({tag, ".quotient"}, bus.quotient, exp);
    chk({tag, ".div_zero"}, W'(bus.div_zero), W'(edz));
    chk({tag, ".ovf"}, W'(bus.ovf), W'(eov));
    take(tag);
  endtask
  initial begin
    int lat;
    logic [W-1:0] held;
    bit seen;
    bus.in_valid = 1'b0;
    bus.dividend = '0;
    bus.divisor = '0;
    bus.abort = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset.out_valid", W'(bus.out_valid), 0);
    chk("reset.quotient", bus.quotient, 0);
    chk("reset.div_zero", W'(bus.div_zero), 0);
    chk("reset.ovf", W'(bus.ovf), 0);
    chk("reset.in_ready", W'(bus.in_ready), 1);
    run("div6_3", 32'h0300_0000, 32'h0180_0000, 32'h0100_0000, 1'b0, 1'b0, ITERS + 2, 1'b1);
    run("div1_3", 32'h0080_0000, 32'h0180_0000, 32'h002A_AAAA, 1'b0, 1'b0, ITERS + 2, 1'b1);
    run("div1_1", 32'h0080_0000, 32'h0080_0000, 32'h0080_0000, 1'b0, 1'b0, ITERS + 2, 1'b1);
    run("div0_3", 32'h0000_0000, 32'h0180_0000, 32'h0000_0000, 1'b0, 1'b0, ITERS + 2, 1'b0);
    run("divzero", 32'h0123_4567, 32'h0000_0000, SAT_POS, 1'b1, 1'b0, 1, 1'b0);
    run("overflow", 32'h6400_0000, 32'h0000_0001, SAT_POS, 1'b0, 1'b1, ITERS + 2, 1'b0);
    start(32'h0300_0000, 32'h0180_0000);
    wait_valid(lat);
    chk("bp.latency", W'(lat), W'(ITERS + 2));
    held = bus.quotient;
    bus.in_valid = 1'b1;
    bus.dividend = 32'h0080_0000;
    bus.divisor = 32'h0000_0000;
    repeat (10) @(negedge clk);
    bus.in_valid = 1'b0;
    chk_tol("bp.quotient", held, 32'h0100_0000);
    chk("bp.quotient_stable", bus.quotient, held);
    chk("bp.in_ready", W'(bus.in_ready), 0);
    chk("bp.out_valid", W'(bus.out_valid), 1);
    chk("bp.div_zero", W'(bus.div_zero), 0);
    take("bp");
    start(32'h0300_0000, 32'h0180_0000);
    repeat (3) @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    chk("abort.in_ready", W'(bus.in_ready), 1);
    chk("abort.out_valid", W'(bus.out_valid), 0);
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      seen |= bus.out_valid;
    end
    chk("abort.no_result", W'(seen), 0);
    run("recover", 32'h0080_0000, 32'h0180_0000, 32'h002A_AAAA, 1'b0, 1'b0, ITERS + 2, 1'b1);
`ifdef GSDIV_SIGNED_EN
    run("neg6_3", 32'hFD00_0000, 32'h0180_0000, 32'hFF00_0000, 1'b0, 1'b0, ITERS + 2, 1'b1);
    run("negdivzero", 32'hFD00_0000, 32'h0000_0000, 32'h8000_0000, 1'b1, 1'b0, 1, 1'b0);
`endif
    start(32'h0300_0000, 32'h0180_0000);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midreset.out_valid", W'(bus.out_valid), 0);
    chk("midreset.quotient", bus.quotient, 0);
    chk("midreset.div_zero", W'(bus.div_zero), 0);
    chk("midreset.ovf", W'(bus.ovf), 0);
    chk("midreset.in_ready", W'(bus.in_ready), 1);
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      seen |= bus.out_valid;
    end
    chk("midreset.no_result", W'(seen), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nv, nf);
    $finish;
  end
endmodule
